hc595_shifter: RTL and testbench



---
 rtl/hc595_pkg.sv | 19 +
 rtl/hc595_shifter_tick_timer.sv | 16 +
 rtl/hc595_shifter.sv | 112 +++++++++++
 tb/tb_hc595_shifter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// hc595_pkg: shared state encoding, 100 MHz board timing defaults and width helpers
package hc595_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_LO   = 3'd1,
    SHIFT_HI   = 3'd2,
    LATCH_WAIT = 3'd3,
    LATCH_HIGH = 3'd4
  } state_e;
  localparam int CLK_DIV_100M     = 50;
  localparam int LATCH_SETUP_100M = 200;
  localparam int LATCH_WIDTH_100M = 200;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hc595_shifter_tick_timer.sv
// hc595_shifter_tick_timer: loadable down-counter with terminal-count flag
// ports: load_i/val_i load a count, tc_o is high while the count is zero
module hc595_shifter_tick_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == '0;
  assign cnt_d = load_i ? val_i : (tc_o ? cnt_q : cnt_q - W'(1));
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/hc595_shifter.sv
// hc595_shifter: serialises one word MSB first into a 74HC595 chain, then pulses RCLK
// ports: data_in/load/ready upstream handshake; ser/srclk/rclk HC595 pins; done one-cycle strobe
module hc595_shifter
  import hc595_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_DIV     = CLK_DIV_100M,
  parameter int LATCH_SETUP = LATCH_SETUP_100M,
  parameter int LATCH_WIDTH = LATCH_WIDTH_100M
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  ser,
  output logic                  srclk,
  output logic                  rclk,
  output logic                  done
);
  localparam int CW = clog2_min1(max3(CLK_DIV, LATCH_SETUP, LATCH_WIDTH));
  localparam int BW = clog2_min1(DATA_WIDTH);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d, done_q, done_d;
  logic                  tld, tc;
  logic [CW-1:0]         tval;
  hc595_shifter_tick_timer #(.W(CW)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (tld),
    .val_i  (tval),
    .tc_o   (tc)
  );
  assign ready = state_q == IDLE;
  assign ser   = ser_q;
  assign srclk = srclk_q;
  assign rclk  = rclk_q;
  assign done  = done_q;
  // each timed state is entered with the timer loaded to its length minus one, so tc marks its last cycle
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    srclk_d = srclk_q;
    rclk_d  = rclk_q;
    done_d  = 1'b0;
    tld     = 1'b0;
    tval    = CW'(CLK_DIV - 1);
    case (state_q)
      IDLE: if (load) begin
        shreg_d = data_in;
        ser_d   = data_in[DATA_WIDTH-1];
        srclk_d = 1'b0;
        bit_d   = '0;
        tld     = 1'b1;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: if (tc) begin
        srclk_d = 1'b1;
        tld     = 1'b1;
        state_d = SHIFT_HI;
      end
      SHIFT_HI: if (tc) begin
        srclk_d = 1'b0;
        tld     = 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          tval    = CW'(LATCH_SETUP - 1);
          state_d = LATCH_WAIT;
        end else begin
          bit_d   = bit_q + BW'(1);
          shreg_d = shreg_q << 1;
          ser_d   = shreg_d[DATA_WIDTH-1];
          state_d = SHIFT_LO;
        end
      end
      LATCH_WAIT: if (tc) begin
        rclk_d  = 1'b1;
        tld     = 1'b1;
        tval    = CW'(LATCH_WIDTH - 1);
        state_d = LATCH_HIGH;
      end
      LATCH_HIGH: if (tc) begin
        rclk_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hc595_shifter.sv
// tb_hc595_shifter: scoreboard bench for hc595_shifter with DATA_WIDTH=8, CLK_DIV=2, LATCH_SETUP=3, LATCH_WIDTH=4
module tb_hc595_shifter;
  localparam int LAT = 2 * 2 * 8 + 3 + 4;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load, ready, ser, srclk, rclk, done;
  int         total = 0, bad = 0, cyc = 0, rise_cnt = 0;
  int         last_rise = 0, last_fall = 0, last_rrise = 0;
  logic       prev_s = 1'b0, prev_r = 1'b0;
  logic       bitq[$];
  int         accq[$], doneq[$];
  hc595_shifter #(.DATA_WIDTH(8), .CLK_DIV(2), .LATCH_SETUP(3), .LATCH_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .ser     (ser),
    .srclk   (srclk),
    .rclk    (rclk),
    .done    (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic miss(input string n);
    total++;
    bad++;
    $display("FAIL %s: event with no expectation or timeout (cycle %0d)", n, cyc);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic flush();
    bitq.delete();
    accq.delete();
    doneq.delete();
  endtask
  task automatic expect_frame(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) bitq.push_back(d[i]);
    accq.push_back(cyc + 1);
    doneq.push_back(cyc + 1 + LAT);
  endtask
  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!ready && n < 200) begin step(); n++; end
    if (!ready) begin miss("send_ready"); return; end
    load = 1'b1;
    data_in = d;
    expect_frame(d);
    step();
    load = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin step(); n++; end
    if (!done) miss("done_timeout");
  endtask
  // monitor: samples on the falling clk edge, pops expectations when the DUT shows an event
  always @(negedge clk) begin
    if (rst) begin
      prev_s = 1'b0;
      prev_r = 1'b0;
      rise_cnt = 0;
    end else begin
      chk("no_overlap", int'(srclk & rclk), 0);
      if (srclk && !prev_s) begin
        if (bitq.size() == 0) miss("srclk_rise");
        else chk("ser_bit", int'(ser), int'(bitq.pop_front()));
        if (rise_cnt == 0) begin
          if (accq.size() == 0) miss("first_rise");
          else chk("first_rise_delay", cyc - accq.pop_front(), 2);
        end else chk("srclk_low_len", cyc - last_fall, 2);
        rise_cnt++;
        last_rise = cyc;
      end
      if (!srclk && prev_s) begin
        chk("srclk_high_len", cyc - last_rise, 2);
        last_fall = cyc;
      end
      if (rclk && !prev_r) begin
        chk("rclk_setup", cyc - last_fall, 3);
        last_rrise = cyc;
      end
      if (!rclk && prev_r) chk("rclk_width", cyc - last_rrise, 4);
      if (done) begin
        if (doneq.size() == 0) miss("done_strobe");
        else chk("done_latency", cyc, doneq.pop_front());
        chk("rises_per_frame", rise_cnt, 8);
        chk("ready_in_done", int'(ready), 1);
        rise_cnt = 0;
      end
      prev_s = srclk;
      prev_r = rclk;
    end
  end
  initial begin
    int hi, n;
    rst = 1'b1;
    load = 1'b0;
    data_in = 8'h00;
    repeat (3) step();
    chk("rst_ser", int'(ser), 0);
    chk("rst_srclk", int'(srclk), 0);
    chk("rst_rclk", int'(rclk), 0);
    chk("rst_done", int'(done), 0);
    load = 1'b1;
    data_in = 8'hFF;
    step();
    chk("rst_ignores_load", int'(srclk | rclk | done | ser), 0);
    load = 1'b0;
    rst = 1'b0;
    step();
    chk("ready_after_rst", int'(ready), 1);
    send(8'hA5);
    wait_done();
    send(8'h81);
    wait_done();
    step();
    load = 1'b1;
    data_in = 8'h3C;
    expect_frame(8'h3C);
    step();
    data_in = 8'hFF;
    hi = 0;
    n = 0;
    while (!done && n < 200) begin
      if (ready) hi++;
      step();
      n++;
    end
    load = 1'b0;
    if (!done) miss("done_timeout_busy");
    chk("ready_while_busy", hi, 0);
    repeat (50) step();
    send(8'hC3);
    n = 0;
    while (rise_cnt != 4 && n < 100) begin step(); n++; end
    if (rise_cnt != 4) miss("fourth_rise");
    chk("in_shift_hi", int'(srclk), 1);
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
    chk("abort_ser", int'(ser), 0);
    chk("abort_srclk", int'(srclk), 0);
    chk("abort_rclk", int'(rclk), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(ready), 1);
    send(8'h55);
    wait_done();
    step();
    send(8'h96);
    n = 0;
    while (!rclk && n < 100) begin step(); n++; end
    if (!rclk) miss("rclk_timeout");
    step();
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
    chk("latch_abort_rclk", int'(rclk), 0);
    chk("latch_abort_done", int'(done), 0);
    repeat (60) step();
    send(8'h5A);
    wait_done();
    repeat (5) step();
    chk("queues_drained", bitq.size() + accq.size() + doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
